msg_ram_uart_tx: RTL and testbench

- Reader/transmitter end of the 7-bit message RAM. The RAM holds a NUL-terminated string such as LF, CR, "ECE433 Fall 2018 ...", CR, LF, NUL.
- On a start request, the block walks the RAM from address 0 and serialises each character onto a UART TX line. It stops at the first NUL or at the last RAM location.
- It drives the RAM address and holds the RAM in read mode (writeOrread=0).

---
 rtl/msg_ram_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_msg_ram_uart_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_ram_uart_tx.sv
// Reads a NUL-terminated string from the message RAM and sends it on a UART TX line.
// Optional MSG_TX_PARITY_EN: 7E1 frames (start, 7 data bits, even parity, stop); otherwise 8N1 with bit 7 = 0.
module msg_ram_uart_tx #(
  parameter int unsigned DataWidth    = 7,
  parameter int unsigned AddrWidth    = 6,
  parameter int unsigned MemorySize   = 43,
  parameter int unsigned ClocksPerBit = 10417
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DataWidth-1:0] ram_dout,
  output logic [AddrWidth-1:0] address,
  output logic                 writeOrread,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntWidth  = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
  localparam int unsigned FrameBits = 8;
  localparam int unsigned IdxWidth  = 3;
`ifdef MSG_TX_PARITY_EN
  localparam int unsigned LastDataBit = DataWidth - 1;
`else
  localparam int unsigned LastDataBit = FrameBits - 1;
`endif

`ifdef MSG_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP, S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_STOP, S_FIN
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   bit_q, bit_d;
  logic [DataWidth-1:0]  shreg_q, shreg_d;
  logic [AddrWidth-1:0]  addr_d;
  logic                  tx_d, busy_d, done_d;
  logic                  bit_end_c;
  logic [FrameBits-1:0]  frame_c;

  assign writeOrread = 1'b0;
  assign bit_end_c   = (cnt_q == CntWidth'(ClocksPerBit - 1));
  // Data byte on the wire; bits above the character width are sent as 0.
  assign frame_c     = FrameBits'(shreg_q);

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      address <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      address <= addr_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; the baud counter clears on every bit boundary and state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    addr_d  = address;
    tx_d    = tx;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
        end
      end

      S_FETCH: begin
        shreg_d = ram_dout;
        if (ram_dout == '0) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = frame_c[0];
        end else begin
          cnt_d = CntWidth'(cnt_q + CntWidth'(1));
        end
      end

      S_DATA: begin
        if (bit_end_c) begin
          if (bit_q == IdxWidth'(LastDataBit)) begin
`ifdef MSG_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^shreg_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = IdxWidth'(bit_q + IdxWidth'(1));
            tx_d  = frame_c[IdxWidth'(bit_q + IdxWidth'(1))];
          end
        end else begin
          cnt_d = CntWidth'(cnt_q + CntWidth'(1));
        end
      end

`ifdef MSG_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = CntWidth'(cnt_q + CntWidth'(1));
        end
      end
`endif

      S_STOP: begin
        if (bit_end_c) begin
          if (address == AddrWidth'(MemorySize - 1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            addr_d  = AddrWidth'(address + AddrWidth'(1));
          end
        end else begin
          cnt_d = CntWidth'(cnt_q + CntWidth'(1));
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        addr_d  = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        addr_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_msg_ram_uart_tx.sv
// Directed bench for msg_ram_uart_tx with ClocksPerBit=4 and a behavioural async-read RAM.
module tb_msg_ram_uart_tx;

  localparam int CPB   = 4;
  localparam int MSIZE = 43;
  localparam int NBITS = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] ram_dout;
  logic [5:0] address;
  logic       writeOrread, tx, busy, done;

  logic [6:0] mem [0:MSIZE-1];
  assign ram_dout = (address < 6'd43) ? mem[address] : 7'd0;

  int checks = 0;
  int errors = 0;

  logic       txq[$];
  logic [6:0] rxq[$];
  int         addr_seq[$];
  int         done_cnt, max_addr, frame_err;
  bit         timed_out;

  msg_ram_uart_tx #(.DataWidth(7), .AddrWidth(6), .MemorySize(MSIZE), .ClocksPerBit(CPB)) dut (
    .clock(clock), .reset(reset), .start(start), .ram_dout(ram_dout),
    .address(address), .writeOrread(writeOrread), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic clear_mem();
    for (int i = 0; i < MSIZE; i++) mem[i] = 7'h00;
  endtask

  // Pulse start on the first cycle (and optionally at pulse_at), record tx per cycle until done plus a tail
  task automatic capture(input int max_cyc, input int pulse_at, input int tail);
    int post;
    int last;
    txq.delete(); addr_seq.delete();
    done_cnt = 0; max_addr = 0; post = 0; timed_out = 1'b1;
    last = int'(address);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clock);
      start = (c == 0 || c == pulse_at) ? 1'b1 : 1'b0;
      @(posedge clock); #1;
      txq.push_back(tx);
      if (done === 1'b1) done_cnt++;
      if (int'(address) > max_addr) max_addr = int'(address);
      if (int'(address) != last) addr_seq.push_back(int'(address));
      last = int'(address);
      if (done_cnt > 0) post++;
      if (post == tail) begin timed_out = 1'b0; break; end
    end
    @(negedge clock); start = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL capture_timeout: done count %0d, required 1 within %0d cycles", done_cnt, max_cyc);
    end
  endtask

  // UART monitor: decode frames from the per-cycle tx record
  task automatic decode_frames();
    int i;
    logic [6:0] ch;
    logic b7;
    rxq.delete(); frame_err = 0; i = 0;
    while (i < txq.size()) begin
      if (txq[i] == 1'b0) begin
        if (i + NBITS*CPB > txq.size()) begin frame_err++; break; end
        for (int s = 0; s < CPB; s++) if (txq[i+s] !== 1'b0) frame_err++;
        for (int k = 0; k < 7; k++) ch[k] = txq[i + CPB*(k+1) + 1];
        b7 = txq[i + CPB*8 + 1];
`ifdef MSG_TX_PARITY_EN
        if (b7 !== ^ch) frame_err++;
`else
        if (b7 !== 1'b0) frame_err++;
`endif
        if (txq[i + CPB*9 + 1] !== 1'b1) frame_err++;
        rxq.push_back(ch);
        i += NBITS*CPB;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || address !== 6'd0 || writeOrread !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: tx=%b busy=%b done=%b addr=%0d wr=%b, required 1 0 0 0 0",
               tx, busy, done, address, writeOrread);
    end
    @(negedge clock); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || address !== 6'd0 || writeOrread !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: tx=%b busy=%b done=%b addr=%0d wr=%b, required 1 0 0 0 0",
                 c, tx, busy, done, address, writeOrread);
      end
    end
  endtask

  task automatic test_single_char();
    logic [9:0] exp;
`ifdef MSG_TX_PARITY_EN
    exp = 10'b11_1000_0110;
`else
    exp = 10'b10_1000_0110;
`endif
    clear_mem(); mem[0] = 7'h43;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_fetch: tx=%b busy=%b, required tx=1 busy=1", tx, busy);
    end
    @(negedge clock); start = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      for (int s = 0; s < CPB; s++) begin
        @(posedge clock); #1;
        checks++;
        if (tx !== exp[k]) begin
          errors++;
          $display("FAIL single_bit%0d_cyc%0d: tx=%b, required %b", k, s, tx, exp[k]);
        end
      end
    end
    @(posedge clock); #1;
    checks++;
    if (address !== 6'd1 || tx !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_fetch2: addr=%0d tx=%b done=%b, required 1 1 0", address, tx, done);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b, required 1 1", done, busy);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || address !== 6'd0) begin
      errors++;
      $display("FAIL single_idle: done=%b busy=%b addr=%0d, required 0 0 0", done, busy, address);
    end
  endtask

  task automatic test_full_message();
    logic [6:0] exp_ch [6];
    int         exp_addr [7];
    exp_ch   = '{7'h0A, 7'h0D, 7'h45, 7'h43, 7'h45, 7'h34};
    exp_addr = '{1, 2, 3, 4, 5, 6, 0};
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = exp_ch[i];
    capture(600, -1, 3);
    decode_frames();
    checks++;
    if (rxq.size() != 6 || frame_err != 0) begin
      errors++;
      $display("FAIL full_frames: got %0d frames, %0d framing errors, required 6 and 0", rxq.size(), frame_err);
    end
    for (int i = 0; i < 6 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== exp_ch[i]) begin
        errors++;
        $display("FAIL full_char%0d: got %h, required %h", i, rxq[i], exp_ch[i]);
      end
    end
    checks++;
    if (addr_seq.size() != 7) begin
      errors++;
      $display("FAIL full_addr_len: %0d address changes, required 7", addr_seq.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (addr_seq[i] != exp_addr[i]) begin
          errors++;
          $display("FAIL full_addr%0d: got %0d, required %0d", i, addr_seq[i], exp_addr[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_no_terminator();
    int bad;
    for (int i = 0; i < MSIZE; i++) mem[i] = 7'h41;
    capture(3000, -1, 3);
    decode_frames();
    bad = 0;
    foreach (rxq[i]) if (rxq[i] !== 7'h41) bad++;
    checks++;
    if (rxq.size() != MSIZE || frame_err != 0 || bad != 0) begin
      errors++;
      $display("FAIL noterm_frames: got %0d frames (%0d wrong chars, %0d framing errors), required 43 'A'",
               rxq.size(), bad, frame_err);
    end
    checks++;
    if (max_addr != MSIZE-1) begin
      errors++;
      $display("FAIL noterm_max_addr: got %0d, required 42", max_addr);
    end
    checks++;
    if (done_cnt != 1 || address !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL noterm_end: done count %0d addr=%0d busy=%b, required 1 0 0", done_cnt, address, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mem(); mem[0] = 7'h45;
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    repeat (18) @(posedge clock);
    #1;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_bit3: tx=%b busy=%b, required 0 1", tx, busy);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || address !== 6'd0) begin
      errors++;
      $display("FAIL midframe_abort: tx=%b busy=%b done=%b addr=%0d, required 1 0 0 0", tx, busy, done, address);
    end
    @(negedge clock); reset = 1'b0;
    capture(200, -1, 3);
    decode_frames();
    checks++;
    if (rxq.size() != 1 || frame_err != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL midframe_resend: %0d frames, %0d framing errors, %0d done, required 1 0 1",
               rxq.size(), frame_err, done_cnt);
    end else begin
      checks++;
      if (rxq[0] !== 7'h45) begin
        errors++;
        $display("FAIL midframe_char: got %h, required 45", rxq[0]);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [6:0] exp_ch [3];
    exp_ch = '{7'h43, 7'h45, 7'h34};
    clear_mem();
    for (int i = 0; i < 3; i++) mem[i] = exp_ch[i];
    capture(600, 20, 60);
    decode_frames();
    checks++;
    if (rxq.size() != 3 || frame_err != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL ignored_start: %0d frames, %0d framing errors, %0d done, required 3 0 1",
               rxq.size(), frame_err, done_cnt);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rxq[i] !== exp_ch[i]) begin
          errors++;
          $display("FAIL ignored_char%0d: got %h, required %h", i, rxq[i], exp_ch[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL ignored_idle: busy=%b tx=%b, required 0 1", busy, tx);
    end
  endtask

  task automatic test_nul_held_start();
    logic exp_done;
    clear_mem();
    @(negedge clock); start = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clock); #1;
      exp_done = (e == 1 || e == 4);
      checks++;
      if (done !== exp_done || tx !== 1'b1) begin
        errors++;
        $display("FAIL nul_edge%0d: done=%b tx=%b, required %b 1", e, done, tx, exp_done);
      end
    end
    @(negedge clock); start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL nul_settle: busy=%b done=%b tx=%b, required 0 0 1", busy, done, tx);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_single_char();
    test_full_message();
    test_no_terminator();
    test_reset_mid_frame();
    test_ignored_start();
    test_nul_held_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
